// File: rtl/m72_pkg.sv
// Shared types for the ioctl byte-to-word packer: FIFO word layout and issue FSM states.
package m72_pkg;

    typedef struct packed {
        logic [24:1] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } pack_word_t;

    localparam int PACK_W = $bits(pack_word_t);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } issue_state_t;

    function automatic pack_word_t make_word(input logic [24:1] addr,
                                             input logic [15:0] data,
                                             input logic [1:0]  be);
        pack_word_t w;
        w.addr = addr;
        w.data = data;
        w.be   = be;
        return w;
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO with occupancy count; a push into a full FIFO is accepted only alongside a pop.
// Latency: 1 cycle push to visible head; no backpressure beyond o_full.
module packer_fifo
    import m72_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic [PACK_W-1:0]         i_push_dat,
    input  logic                      i_pop,
    output logic [PACK_W-1:0]         o_pop_dat,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [PACK_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_push_dat;
        end
    end

    assign o_pop_dat = r_mem[r_rp];
    assign o_count   = r_count;
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);

endmodule

// File: rtl/ioctl_word_packer.sv
// Packs data_io download bytes into 16-bit SDRAM words and issues them over a toggle req/ack port.
// Latency: 2 cycles pair-complete to sdr_req toggle; ioctl_wait when FIFO nearly full or staging busy.
module ioctl_word_packer
    import m72_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] BASE_ADDR  = 25'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:0] sdr_addr,
    output logic [15:0] sdr_data,
    output logic [1:0]  sdr_be,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic        done,
    output logic        overflow
);
    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

    logic [24:0]       w_eff_addr;
    logic              w_wr;
    logic              w_fall;
    logic              w_match;
    pack_word_t        w_held_word;
    pack_word_t        w_ev0;
    pack_word_t        w_ev1;
    logic [1:0]        w_ev_n;
    logic              w_hold_set;
    logic              w_hold_clr;
    logic              w_stg_load;
    pack_word_t        w_stg_word;
    logic              w_push;
    pack_word_t        w_push_word;
    logic              w_drop;
    logic              w_pop;
    logic              w_quiet;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [PACK_W-1:0] w_fifo_rd;
    pack_word_t        w_head;
    issue_state_t      w_state_nxt;

    logic              r_hold_vld;
    logic [24:1]       r_hold_addr;
    logic [7:0]        r_hold_byte;
    logic              r_stg_vld;
    pack_word_t        r_stg;
    logic              r_downl_d;
    logic              r_armed;
    logic              r_done;
    logic              r_overflow;
    logic              r_req;
    logic [24:0]       r_addr;
    logic [15:0]       r_data;
    logic [1:0]        r_be;
    issue_state_t      r_state;

    assign w_eff_addr  = ioctl_addr + BASE_ADDR;
    assign w_wr        = ioctl_wr && ioctl_downl;
    assign w_fall      = r_downl_d && !ioctl_downl;
    assign w_match     = r_hold_vld && (r_hold_addr == w_eff_addr[24:1]);
    assign w_held_word = make_word(r_hold_addr, {8'h00, r_hold_byte}, 2'b01);

    // Each byte event yields zero, one or two words; w_ev0 always leaves first.
    always_comb begin
        w_ev_n     = 2'd0;
        w_ev0      = '0;
        w_ev1      = '0;
        w_hold_set = 1'b0;
        w_hold_clr = 1'b0;
        if (w_wr && !w_eff_addr[0]) begin
            w_hold_set = 1'b1;
            if (r_hold_vld) begin
                w_ev_n = 2'd1;
                w_ev0  = w_held_word;
            end
        end else if (w_wr) begin
            w_hold_clr = 1'b1;
            if (w_match) begin
                w_ev_n = 2'd1;
                w_ev0  = make_word(r_hold_addr, {ioctl_dout, r_hold_byte}, 2'b11);
            end else if (r_hold_vld) begin
                w_ev_n = 2'd2;
                w_ev0  = w_held_word;
                w_ev1  = make_word(w_eff_addr[24:1], {ioctl_dout, 8'h00}, 2'b10);
            end else begin
                w_ev_n = 2'd1;
                w_ev0  = make_word(w_eff_addr[24:1], {ioctl_dout, 8'h00}, 2'b10);
            end
        end else if (w_fall && r_hold_vld) begin
            w_hold_clr = 1'b1;
            w_ev_n     = 2'd1;
            w_ev0      = w_held_word;
        end
    end

    // Staging drains ahead of new words; a third word in one cycle has nowhere to go and is dropped.
    always_comb begin
        w_push      = 1'b0;
        w_push_word = '0;
        w_stg_load  = 1'b0;
        w_stg_word  = '0;
        w_drop      = 1'b0;
        if (r_stg_vld) begin
            w_push      = 1'b1;
            w_push_word = r_stg;
            if (w_ev_n != 2'd0) begin
                w_stg_load = 1'b1;
                w_stg_word = w_ev0;
            end
            w_drop = (w_ev_n == 2'd2);
        end else if (w_ev_n != 2'd0) begin
            w_push      = 1'b1;
            w_push_word = w_ev0;
            if (w_ev_n == 2'd2) begin
                w_stg_load = 1'b1;
                w_stg_word = w_ev1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_vld  <= 1'b0;
            r_hold_addr <= '0;
            r_hold_byte <= '0;
        end else if (w_hold_set) begin
            r_hold_vld  <= 1'b1;
            r_hold_addr <= w_eff_addr[24:1];
            r_hold_byte <= ioctl_dout;
        end else if (w_hold_clr) begin
            r_hold_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg_vld  <= 1'b0;
            r_stg      <= '0;
            r_downl_d  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_stg_vld  <= w_stg_load;
            if (w_stg_load) begin
                r_stg <= w_stg_word;
            end
            r_downl_d  <= ioctl_downl;
            r_overflow <= r_overflow || w_drop || (w_push && w_fifo_full && !w_pop);
        end
    end

    packer_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat (w_push_word),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_rd),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_head = w_fifo_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (sdr_ack == r_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset aligns req to ack so any in-flight request is simply forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req  <= sdr_ack;
            r_addr <= '0;
            r_data <= '0;
            r_be   <= '0;
        end else if (w_pop) begin
            r_req  <= !r_req;
            r_addr <= {w_head.addr, 1'b0};
            r_data <= w_head.data;
            r_be   <= w_head.be;
        end
    end

    assign w_quiet = !ioctl_downl && !r_hold_vld && !r_stg_vld && w_fifo_empty
                     && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_armed && w_quiet;
            if (ioctl_downl) begin
                r_armed <= 1'b1;
            end else if (w_quiet) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign ioctl_wait = (w_fifo_count >= WAIT_LVL) || r_stg_vld;
    assign sdr_addr   = r_addr;
    assign sdr_data   = r_data;
    assign sdr_be     = r_be;
    assign sdr_req    = r_req;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
